// File: rtl/mem_host_pkg.sv
// Shared types for the host line responder: line width, request opcodes and
// the request FSM states.
package mem_host_pkg;

    localparam int LINE_BITS     = 512;
    localparam int LINE_OFFSET_W = 6;
    localparam int CNT_W         = 8;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RSVD = 2'b11
    } host_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ISSUE = 2'b10,
        ST_RESP  = 2'b11
    } host_state_e;

endpackage

// File: rtl/host_line_ram.sv
// Single-port synchronous line store, DEPTH x 512 bits, one-cycle registered read.
// Read and write share the index; a read during a write returns the old line.
module host_line_ram
    import mem_host_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  line_t            wdata,
    output line_t            rdata
);

    line_t r_mem [DEPTH];
    line_t r_rdata;

    // Write when enabled and always register the addressed line.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        r_rdata <= r_mem[idx];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/host_line_responder.sv
// Host-side line responder: accepts one line read/write request at a time,
// waits a fixed latency, performs the RAM access in ISSUE and reports
// completion in RESP. Outside ISSUE the RAM port belongs to the backdoor.
// The done pulse lands in the cycle following edge accept+LATENCY, so the
// request always passes through WAIT (LATENCY-1 cycles), including LATENCY==2.
// LATENCY must lie in 2..255.
module host_line_responder
    import mem_host_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op_host,
    input  logic [31:0]      AddrOut_host,
    input  line_t            DataOut_host,
    output line_t            DataIn_host,
    output logic             rd_valid_host,
    output logic             tx_done_host,
    input  logic             bd_we,
    input  logic [IDX_W-1:0] bd_idx,
    input  line_t            bd_data,
    output logic             bd_ack
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 2);

    host_state_e      r_state;
    host_state_e      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;

    host_op_e         r_op;
    logic [IDX_W-1:0] r_idx;
    line_t            r_wdata;
    line_t            r_dout;

    logic             w_issue;
    logic             w_ram_we;
    logic [IDX_W-1:0] w_ram_idx;
    line_t            w_ram_wdata;
    line_t            w_ram_rdata;

    // Offset bits and bits above the index field do not select a line.
    logic             w_unused_addr;
    assign w_unused_addr = ^{AddrOut_host[31:LINE_OFFSET_W+IDX_W],
                             AddrOut_host[LINE_OFFSET_W-1:0]};

    // Next-state and latency counter logic; requests are sampled only in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (op_host != OP_IDLE) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_ISSUE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_ISSUE: w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State, counter and held read line; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (rd_valid_host) begin
                r_dout <= w_ram_rdata;
            end
        end
    end

    // Capture the request on acceptance; the initiator may change inputs afterwards.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= host_op_e'(op_host);
            r_idx   <= AddrOut_host[LINE_OFFSET_W +: IDX_W];
            r_wdata <= DataOut_host;
        end
    end

    // RAM port mux: ISSUE owns the port, otherwise the backdoor drives it.
    always_comb begin
        w_issue     = (r_state == ST_ISSUE);
        w_ram_we    = bd_we;
        w_ram_idx   = bd_idx;
        w_ram_wdata = bd_data;
        if (w_issue) begin
            w_ram_we    = (r_op == OP_WR);
            w_ram_idx   = r_idx;
            w_ram_wdata = r_wdata;
        end
    end

    assign bd_ack = bd_we && !w_issue;

    host_line_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .idx   (w_ram_idx),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    // RESP shows the freshly read line; otherwise the last read line is held.
    assign tx_done_host  = (r_state == ST_RESP);
    assign rd_valid_host = (r_state == ST_RESP) && (r_op == OP_RD);
    assign DataIn_host   = rd_valid_host ? w_ram_rdata : r_dout;

endmodule

// File: tb/tb_host_line_responder.sv
// Self-checking bench for host_line_responder: three instances with
// LATENCY 4 (directed), 2 and 7 (randomized), checked against a line-array model.
`timescale 1ns/1ps
module tb_host_line_responder;
    import mem_host_pkg::*;

    localparam int DEPTH = 1024;
    localparam int IDX_W = 10;
    localparam int N_DUT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       op_r     [N_DUT];
    logic [31:0]      addr_r   [N_DUT];
    line_t            wdat_r   [N_DUT];
    line_t            din_w    [N_DUT];
    logic             rdv_w    [N_DUT];
    logic             done_w   [N_DUT];
    logic             bd_we_r  [N_DUT];
    logic [IDX_W-1:0] bd_idx_r [N_DUT];
    line_t            bd_data_r[N_DUT];
    logic             bd_ack_w [N_DUT];

    line_t model    [N_DUT][DEPTH];
    line_t last_din [N_DUT];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N_DUT; gi++) begin : g_dut
            host_line_responder #(
                .DEPTH   (DEPTH),
                .LATENCY ((gi == 0) ? 4 : (gi == 1) ? 2 : 7)
            ) u_dut (
                .clk           (clk),
                .rst_n         (rst_n),
                .op_host       (op_r[gi]),
                .AddrOut_host  (addr_r[gi]),
                .DataOut_host  (wdat_r[gi]),
                .DataIn_host   (din_w[gi]),
                .rd_valid_host (rdv_w[gi]),
                .tx_done_host  (done_w[gi]),
                .bd_we         (bd_we_r[gi]),
                .bd_idx        (bd_idx_r[gi]),
                .bd_data       (bd_data_r[gi]),
                .bd_ack        (bd_ack_w[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 7;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd64) % 32'(DEPTH));
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    // Backdoor write, retried while the DUT refuses it.
    task automatic bd_write(input int k, input int idx, input line_t d);
        int tries;
        bit ok;
        tries = 0;
        ok = 1'b0;
        while (!ok && tries < 8) begin
            bd_we_r[k] = 1'b1;
            bd_idx_r[k] = IDX_W'(idx);
            bd_data_r[k] = d;
            #1;
            ok = bd_ack_w[k];
            @(negedge clk);
            tries++;
        end
        bd_we_r[k] = 1'b0;
        model[k][idx] = d;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bd_write dut%0d idx=%0d: bd_ack never seen, wanted 1", k, idx);
        end
    endtask

    // One request from presentation to the IDLE cycle after done; optional
    // input glitching after acceptance and one backdoor write at cycle bd_at.
    task automatic do_req(input int k, input logic [1:0] op, input logic [31:0] a,
                          input line_t d, input bit glitch, input int bd_at,
                          input int bd_i, input line_t bd_d,
                          output int n_done, output logic rdv_o, output line_t din_o,
                          output logic bd_ack_o, output logic post_done,
                          output logic post_rdv, output line_t post_din);
        int n;
        int lat;
        n = 0;
        lat = lat_of(k);
        n_done = -1;
        rdv_o = 1'b0;
        din_o = '0;
        bd_ack_o = 1'b0;
        op_r[k] = op;
        addr_r[k] = a;
        wdat_r[k] = d;
        while (n_done < 0 && n < lat + 6) begin
            @(negedge clk);
            n++;
            if (n == bd_at + 1) bd_we_r[k] = 1'b0;
            if (done_w[k]) begin
                n_done = n;
                rdv_o = rdv_w[k];
                din_o = din_w[k];
            end else begin
                if (bd_at > 0 && n == bd_at) begin
                    bd_we_r[k] = 1'b1;
                    bd_idx_r[k] = IDX_W'(bd_i);
                    bd_data_r[k] = bd_d;
                    #1;
                    bd_ack_o = bd_ack_w[k];
                end
                if (glitch) begin
                    op_r[k] = 2'($urandom());
                    addr_r[k] = $urandom();
                    wdat_r[k] = rand_line();
                end
            end
        end
        @(negedge clk);
        bd_we_r[k] = 1'b0;
        post_done = done_w[k];
        post_rdv = rdv_w[k];
        post_din = din_w[k];
        op_r[k] = 2'b00;
        $display("dut%0d op=%0d addr=%h done@%0d rdv=%0b bd_at=%0d bd_ack=%0b",
                 k, op, a, n_done, rdv_o, bd_at, bd_ack_o);
    endtask

    task automatic test_reset();
        int n_done;
        logic rdv, ba, pd, pr;
        line_t din, pdin;
        bit saw_done;
        saw_done = 1'b0;
        for (int k = 0; k < N_DUT; k++) begin
            checks++;
            if (done_w[k] !== 1'b0 || rdv_w[k] !== 1'b0 || din_w[k] !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: done=%b rdv=%b din!=0, wanted all 0", k, done_w[k], rdv_w[k]);
            end
        end
        do_req(0, OP_RD, 32'(9 * 64), '0, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        checks++;
        if (din !== model[0][9]) begin
            errors++;
            $display("FAIL reset_preread: got %h want %h", din[63:0], model[0][9][63:0]);
        end
        op_r[0] = OP_WR;
        addr_r[0] = 32'(9 * 64);
        wdat_r[0] = ~model[0][9];
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        op_r[0] = 2'b00;
        repeat (2) begin
            @(negedge clk);
            if (done_w[0]) saw_done = 1'b1;
        end
        checks++;
        if (rdv_w[0] !== 1'b0 || din_w[0] !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdv=%b din_lo=%h, wanted 0 and 0", rdv_w[0], din_w[0][63:0]);
        end
        rst_n = 1'b1;
        for (int k = 0; k < N_DUT; k++) last_din[k] = '0;
        repeat (10) begin
            @(negedge clk);
            if (done_w[0]) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_done: saw tx_done=1, wanted none");
        end
        do_req(0, OP_RD, 32'(9 * 64), '0, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        last_din[0] = model[0][9];
        checks++;
        if (din !== model[0][9]) begin
            errors++;
            $display("FAIL reset_no_commit: got %h want %h", din[63:0], model[0][9][63:0]);
        end
    endtask

    task automatic test_read();
        int n_done;
        logic rdv, ba, pd, pr;
        line_t din, pdin, pat;
        pat = {16{32'hDEAD_BEEF}};
        bd_write(0, 5, pat);
        do_req(0, OP_RD, 32'h0000_0140, '0, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        last_din[0] = pat;
        checks++;
        if (n_done != 5) begin errors++; $display("FAIL read_latency: done at %0d want 5", n_done); end
        checks++;
        if (rdv !== 1'b1) begin errors++; $display("FAIL read_rdv: got %b want 1", rdv); end
        checks++;
        if (din !== pat) begin errors++; $display("FAIL read_data: got %h want %h", din[63:0], pat[63:0]); end
        checks++;
        if (pd !== 1'b0 || pr !== 1'b0) begin
            errors++;
            $display("FAIL read_pulse: next cycle done=%b rdv=%b want 0 0", pd, pr);
        end
        checks++;
        if (pdin !== pat) begin errors++; $display("FAIL read_hold: got %h want %h", pdin[63:0], pat[63:0]); end
    endtask

    task automatic test_write_offset();
        int n_done;
        logic rdv, ba, pd, pr;
        line_t din, pdin, wl;
        wl = '0;
        wl[31:0] = 32'h1234_5678;
        do_req(0, OP_WR, 32'h0000_0180, wl, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        model[0][6] = wl;
        checks++;
        if (n_done != 5 || rdv !== 1'b0) begin
            errors++;
            $display("FAIL write_done: done at %0d rdv=%b want 5 and 0", n_done, rdv);
        end
        checks++;
        if (din !== last_din[0]) begin
            errors++;
            $display("FAIL write_hold: got %h want %h", din[63:0], last_din[0][63:0]);
        end
        do_req(0, OP_RD, 32'h0000_01BC, '0, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        last_din[0] = wl;
        checks++;
        if (din !== wl || rdv !== 1'b1) begin
            errors++;
            $display("FAIL write_readback: got %h rdv=%b want %h rdv=1", din[63:0], rdv, wl[63:0]);
        end
    endtask

    task automatic test_alias();
        int n_done;
        logic rdv, ba, pd, pr;
        line_t din, pdin, wl;
        wl = rand_line();
        do_req(0, OP_WR, 32'h0001_0040, wl, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        model[0][idx_of(32'h0001_0040)] = wl;
        do_req(0, OP_RD, 32'h0000_0040, '0, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        last_din[0] = model[0][idx_of(32'h0000_0040)];
        checks++;
        if (din !== wl) begin
            errors++;
            $display("FAIL alias_read: got %h want %h", din[63:0], wl[63:0]);
        end
    endtask

    task automatic test_reserved();
        int n_done;
        logic rdv, ba, pd, pr;
        line_t din, pdin, old8;
        old8 = model[0][8];
        do_req(0, OP_RSVD, 32'h0000_0200, rand_line(), 1'b0, 4, 8, ~old8,
               n_done, rdv, din, ba, pd, pr, pdin);
        checks++;
        if (n_done != 5 || rdv !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_done: done at %0d rdv=%b want 5 and 0", n_done, rdv);
        end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL rsvd_bd_issue: bd_ack=%b want 0", ba); end
        checks++;
        if (din !== last_din[0]) begin
            errors++;
            $display("FAIL rsvd_hold: got %h want %h", din[63:0], last_din[0][63:0]);
        end
        do_req(0, OP_RD, 32'h0000_0200, '0, 1'b0, 0, 0, '0, n_done, rdv, din, ba, pd, pr, pdin);
        last_din[0] = old8;
        checks++;
        if (din !== old8) begin
            errors++;
            $display("FAIL rsvd_unchanged: got %h want %h", din[63:0], old8[63:0]);
        end
    endtask

    task automatic test_bd_during_wait();
        int n_done;
        logic rdv, ba, pd, pr;
        line_t din, pdin, x;
        x = rand_line();
        do_req(0, OP_RD, 32'(20 * 64), '0, 1'b0, 2, 20, x, n_done, rdv, din, ba, pd, pr, pdin);
        model[0][20] = x;
        last_din[0] = x;
        checks++;
        if (ba !== 1'b1) begin errors++; $display("FAIL bdwait_ack: bd_ack=%b want 1", ba); end
        checks++;
        if (din !== x) begin errors++; $display("FAIL bdwait_data: got %h want %h", din[63:0], x[63:0]); end
    endtask

    task automatic test_random(input int k, input int n_ops);
        int lat, idx, bd_at, bd_i, n_done, ie;
        logic [1:0] op;
        logic [31:0] a;
        line_t d, bd_d, din, pdin, exp_din;
        logic rdv, ba, pd, pr, exp_ack;
        bit glitch;
        lat = lat_of(k);
        for (int t = 0; t < n_ops; t++) begin
            op = 2'($urandom_range(1, 3));
            idx = $urandom_range(0, 15);
            a = {16'($urandom()), 10'(idx), 6'($urandom())};
            d = rand_line();
            glitch = 1'($urandom());
            bd_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
            bd_i = $urandom_range(0, 15);
            bd_d = rand_line();
            do_req(k, op, a, d, glitch, bd_at, bd_i, bd_d, n_done, rdv, din, ba, pd, pr, pdin);
            exp_ack = (bd_at != lat);
            if (bd_at > 0 && exp_ack) model[k][bd_i] = bd_d;
            ie = idx_of(a);
            exp_din = last_din[k];
            if (op == OP_RD) exp_din = model[k][ie];
            else if (op == OP_WR) model[k][ie] = d;
            last_din[k] = exp_din;
            checks++;
            if (n_done != lat + 1) begin
                errors++;
                $display("FAIL rnd%0d_latency t=%0d: done at %0d want %0d", k, t, n_done, lat + 1);
            end
            checks++;
            if (rdv !== (op == OP_RD)) begin
                errors++;
                $display("FAIL rnd%0d_rdv t=%0d: got %b want %b", k, t, rdv, (op == OP_RD));
            end
            checks++;
            if (din !== exp_din) begin
                errors++;
                $display("FAIL rnd%0d_data t=%0d: got %h want %h", k, t, din[127:0], exp_din[127:0]);
            end
            checks++;
            if (pd !== 1'b0 || pr !== 1'b0 || pdin !== exp_din) begin
                errors++;
                $display("FAIL rnd%0d_after t=%0d: done=%b rdv=%b held_ok=%b want 0 0 1",
                         k, t, pd, pr, (pdin === exp_din));
            end
            if (bd_at > 0) begin
                checks++;
                if (ba !== exp_ack) begin
                    errors++;
                    $display("FAIL rnd%0d_bd_ack t=%0d: got %b want %b", k, t, ba, exp_ack);
                end
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < N_DUT; k++) begin
            op_r[k] = 2'b00;
            addr_r[k] = '0;
            wdat_r[k] = '0;
            bd_we_r[k] = 1'b0;
            bd_idx_r[k] = '0;
            bd_data_r[k] = '0;
            last_din[k] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N_DUT; k++)
            for (int i = 0; i < DEPTH; i++) bd_write(k, i, rand_line());
        test_reset();
        test_read();
        test_write_offset();
        test_alias();
        test_reserved();
        test_bd_during_wait();
        test_random(1, 500);
        test_random(2, 500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
